// File: rtl/agc_timing_pkg.sv
// agc_timing_pkg: shared cycle-sequencer states, stage count and time-pulse indices.
package agc_timing_pkg;
    localparam int NSTAGE = 12;
    typedef enum logic [3:0] {
        STBY, PWRON, TP1, TP2, TP3, TP4, TP5, TP6,
        TP7, TP8, TP9, TP10, TP11, TP12, SRLSE, WAIT
    } state_t;
    localparam int T01 = 0;
    localparam int T02 = 1;
    localparam int T03 = 2;
    localparam int T04 = 3;
    localparam int T05 = 4;
    localparam int T06 = 5;
    localparam int T07 = 6;
    localparam int T08 = 7;
    localparam int T09 = 8;
    localparam int T10 = 9;
    localparam int T11 = 10;
    localparam int T12 = 11;
endpackage

// File: rtl/tpg.sv
// tpg: sequences the memory-cycle time pulses T01..T12 from timer strobes, with
// standby, power-on hold and monitor single-step.
module tpg #(
    parameter int NSTAGE = agc_timing_pkg::NSTAGE
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        ct,
    input  logic        gojam,
    input  logic        stop,
    input  logic        sby,
    input  logic        strt2,
    input  logic        mstp,
    input  logic        mstrtp,
    output logic [11:0] t,
    output logic        t12,
    output logic        stbf,
    output logic        mwait
);
    import agc_timing_pkg::*;
    localparam state_t TP_LAST = state_t'(4'(int'(TP1) + NSTAGE - 1));
    state_t r_state;
    state_t w_next;
    logic   r_start_pend;
    logic   w_adv;
    logic   w_go;
    logic   w_is_tp;
    assign w_adv = ct & ~stop;
    // a start pulse landing on the advancing edge itself still releases WAIT
    assign w_go  = r_start_pend | mstrtp | ~mstp;
    always_comb begin
        w_next = r_state;
        case (r_state)
            STBY:    w_next = sby ? STBY : PWRON;
            PWRON:   w_next = strt2 ? PWRON : TP1;
            SRLSE:   w_next = WAIT;
            WAIT:    w_next = w_go ? TP1 : WAIT;
            default: w_next = (r_state != TP_LAST) ? state_t'(r_state + 4'd1) :
                              mstp ? SRLSE : sby ? STBY : TP1;
        endcase
    end
    always_ff @(posedge clock) begin
        if (rst || gojam) begin
            r_state      <= STBY;
            r_start_pend <= 1'b0;
        end else begin
            if (w_adv) r_state <= w_next;
            r_start_pend <= (w_adv && r_state == WAIT && w_go) ? 1'b0 : (r_start_pend | mstrtp);
        end
    end
    assign w_is_tp = (r_state >= TP1) && (r_state <= TP_LAST);
    assign t       = w_is_tp ? (12'(1) << (r_state - TP1)) : 12'd0;
    assign t12     = t[T12];
    assign stbf    = (r_state == STBY);
    assign mwait   = (r_state == WAIT);
endmodule

// File: tb/tb_tpg.sv
// tb_tpg: directed scenario tests for the time pulse generator.
module tb_tpg;
    logic        clock = 1'b0;
    logic        rst, ct, gojam, stop, sby, strt2, mstp, mstrtp;
    logic [11:0] t;
    logic        t12, stbf, mwait;
    int          checks = 0;
    int          fails  = 0;

    tpg dut (
        .clock (clock), .rst (rst), .ct (ct), .gojam (gojam), .stop (stop),
        .sby (sby), .strt2 (strt2), .mstp (mstp), .mstrtp (mstrtp),
        .t (t), .t12 (t12), .stbf (stbf), .mwait (mwait)
    );

    always #5 clock = ~clock;

    // one idle clock then a one-clock ct; returns on a falling edge with the new state visible
    task automatic strobe(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            @(negedge clock) ct = 1'b1;
            @(negedge clock) ct = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ct = 1'b0; gojam = 1'b0; stop = 1'b0; sby = 1'b0;
        strt2 = 1'b1; mstp = 1'b0; mstrtp = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (t !== 12'h000 || t12 !== 1'b0 || stbf !== 1'b1 || mwait !== 1'b0) begin
            fails++;
            $display("FAIL reset: t=%h t12=%b stbf=%b mwait=%b, want t=000 t12=0 stbf=1 mwait=0", t, t12, stbf, mwait);
        end
    endtask

    task automatic test_power_up;
        int pulses = 0;
        logic [11:0] exp;
        @(negedge clock) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe();
            checks++;
            if (t !== 12'h000 || stbf !== 1'b0) begin
                fails++;
                $display("FAIL pwron_hold[%0d]: t=%h stbf=%b, want t=000 stbf=0", i, t, stbf);
            end
        end
        strt2 = 1'b0;
        strobe();
        checks++;
        if (t !== 12'h001) begin
            fails++;
            $display("FAIL first_t01: t=%h, want 001", t);
        end
        for (int i = 1; i <= 24; i++) begin
            strobe();
            exp = 12'h001 << (i % 12);
            if (t12) pulses++;
            checks++;
            if (t !== exp) begin
                fails++;
                $display("FAIL sweep[%0d]: t=%h, want %h", i, t, exp);
            end
        end
        checks++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL t12_count: got %0d, want 2", pulses);
        end
    endtask

    task automatic test_stop;
        strobe(4);
        checks++;
        if (t !== 12'h010) begin
            fails++;
            $display("FAIL reach_t05: t=%h, want 010", t);
        end
        stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobe();
            checks++;
            if (t !== 12'h010) begin
                fails++;
                $display("FAIL stop_hold[%0d]: t=%h, want 010", i, t);
            end
        end
        stop = 1'b0;
        strobe();
        checks++;
        if (t !== 12'h020) begin
            fails++;
            $display("FAIL stop_resume: t=%h, want 020", t);
        end
    endtask

    task automatic test_gojam;
        strobe();
        checks++;
        if (t !== 12'h040) begin
            fails++;
            $display("FAIL reach_t07: t=%h, want 040", t);
        end
        @(negedge clock) begin gojam = 1'b1; ct = 1'b1; end
        @(negedge clock) begin gojam = 1'b0; ct = 1'b0; end
        checks++;
        if (t !== 12'h000 || stbf !== 1'b1) begin
            fails++;
            $display("FAIL gojam: t=%h stbf=%b, want t=000 stbf=1", t, stbf);
        end
        strobe();
        checks++;
        if (t !== 12'h000 || stbf !== 1'b0) begin
            fails++;
            $display("FAIL gojam_pwron: t=%h stbf=%b, want t=000 stbf=0", t, stbf);
        end
        strobe();
        checks++;
        if (t !== 12'h001) begin
            fails++;
            $display("FAIL gojam_t01: t=%h, want 001", t);
        end
    endtask

    task automatic test_single_step;
        mstp = 1'b1;
        strobe(11);
        checks++;
        if (t !== 12'h800 || t12 !== 1'b1) begin
            fails++;
            $display("FAIL reach_t12: t=%h t12=%b, want t=800 t12=1", t, t12);
        end
        strobe();
        checks++;
        if (t !== 12'h000 || mwait !== 1'b0 || stbf !== 1'b0) begin
            fails++;
            $display("FAIL srlse: t=%h mwait=%b stbf=%b, want t=000 mwait=0 stbf=0", t, mwait, stbf);
        end
        strobe();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t !== 12'h000 || mwait !== 1'b1) begin
                fails++;
                $display("FAIL wait_hold[%0d]: t=%h mwait=%b, want t=000 mwait=1", i, t, mwait);
            end
            if (i < 3) strobe();
        end
        @(negedge clock) mstrtp = 1'b1;
        @(negedge clock) mstrtp = 1'b0;
        repeat (2) @(negedge clock);
        strobe();
        checks++;
        if (t !== 12'h001 || mwait !== 1'b0) begin
            fails++;
            $display("FAIL step_latched: t=%h mwait=%b, want t=001 mwait=0", t, mwait);
        end
        strobe(13);
        @(negedge clock) begin ct = 1'b1; mstrtp = 1'b1; end
        @(negedge clock) begin ct = 1'b0; mstrtp = 1'b0; end
        checks++;
        if (t !== 12'h001) begin
            fails++;
            $display("FAIL step_coincident: t=%h, want 001", t);
        end
        strobe(13);
        mstp = 1'b0;
        strobe();
        checks++;
        if (t !== 12'h001 || mwait !== 1'b0) begin
            fails++;
            $display("FAIL mstp_drop: t=%h mwait=%b, want t=001 mwait=0", t, mwait);
        end
    endtask

    task automatic test_standby;
        strobe(2);
        checks++;
        if (t !== 12'h004) begin
            fails++;
            $display("FAIL reach_t03: t=%h, want 004", t);
        end
        sby = 1'b1;
        for (int i = 3; i < 12; i++) begin
            strobe();
            checks++;
            if (t !== (12'h001 << i) || stbf !== 1'b0) begin
                fails++;
                $display("FAIL sby_complete[%0d]: t=%h stbf=%b, want t=%h stbf=0", i, t, stbf, 12'h001 << i);
            end
        end
        strobe(2);
        checks++;
        if (t !== 12'h000 || stbf !== 1'b1) begin
            fails++;
            $display("FAIL sby_enter: t=%h stbf=%b, want t=000 stbf=1", t, stbf);
        end
        sby = 1'b0;
        strobe();
        checks++;
        if (t !== 12'h000 || stbf !== 1'b0) begin
            fails++;
            $display("FAIL sby_exit: t=%h stbf=%b, want t=000 stbf=0", t, stbf);
        end
        strobe();
        checks++;
        if (t !== 12'h001) begin
            fails++;
            $display("FAIL sby_t01: t=%h, want 001", t);
        end
    endtask

    task automatic test_reset_wait;
        mstp = 1'b1;
        strobe(13);
        checks++;
        if (mwait !== 1'b1) begin
            fails++;
            $display("FAIL rw_wait: mwait=%b, want 1", mwait);
        end
        @(negedge clock) mstrtp = 1'b1;
        @(negedge clock) mstrtp = 1'b0;
        @(negedge clock) rst = 1'b1;
        @(negedge clock) rst = 1'b0;
        checks++;
        if (stbf !== 1'b1 || mwait !== 1'b0 || t !== 12'h000) begin
            fails++;
            $display("FAIL rw_reset: stbf=%b mwait=%b t=%h, want stbf=1 mwait=0 t=000", stbf, mwait, t);
        end
        strobe(2);
        checks++;
        if (t !== 12'h001) begin
            fails++;
            $display("FAIL rw_t01: t=%h, want 001", t);
        end
        strobe(13);
        for (int i = 0; i < 3; i++) begin
            strobe();
            checks++;
            if (mwait !== 1'b1 || t !== 12'h000) begin
                fails++;
                $display("FAIL rw_no_spurious[%0d]: mwait=%b t=%h, want mwait=1 t=000", i, mwait, t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_stop();
        test_gojam();
        test_single_step();
        test_standby();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
